extend_unit: RTL and testbench
==============================

EXTEND_UNIT -- requirements
Module: Extend

Interface
REQ-001 Parameters: none; data width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 valid_in  input  1  instr/immsrc/LuiOP are valid this cycle.
REQ-005 immsrc  input  2  format select: 00=I, 01=S, 10=B, 11=J.
REQ-006 instr  input  32  full RV32I instruction word carrying the immediate.
REQ-007 LuiOP  input  1  select U-type (LUI/AUIPC) immediate; overrides immsrc.
REQ-008 immext  output  32  registered sign-extended immediate.
REQ-009 valid_out  output  1  immext holds a result computed from a valid_in=1 cycle.

Function
REQ-010 Next-value computation SHALL be combinational from instr, immsrc and LuiOP; immext SHALL be registered, with 1-cycle latency from valid_in to valid_out.
REQ-011 LuiOP=1 SHALL yield {instr[31:12], 12'b0}, regardless of immsrc.
REQ-012 LuiOP=0, immsrc=00 (I) SHALL yield {20{instr[31]}, instr[31:20]}.
REQ-013 LuiOP=0, immsrc=01 (S) SHALL yield {20{instr[31]}, instr[31:25], instr[11:7]}.
REQ-014 LuiOP=0, immsrc=10 (B) SHALL yield {19{instr[31]}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
REQ-015 LuiOP=0, immsrc=11 (J) SHALL yield {11{instr[31]}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
REQ-016 B and J results SHALL always have bit 0 = 0; U results SHALL always have bits 11:0 = 0.
REQ-017 Sign bit SHALL always be instr[31]; no other instr bit SHALL affect the upper sign-fill bits.
REQ-018 valid_out SHALL equal valid_in delayed by one cycle (outside reset).
REQ-019 Unknown or X on immsrc is not a legal input; all four encodings SHALL be decoded, with no default or illegal output.
REQ-020 Back-to-back valid_in cycles SHALL produce back-to-back results with no bubbles (throughput 1 per cycle).

Reset
REQ-021 While rst=1 at a rising clk edge, immext SHALL become 0x00000000 and valid_out SHALL become 0.
REQ-022 rst SHALL take priority over valid_in in the same cycle; an input presented during reset SHALL be discarded.
REQ-023 On the first edge after rst deasserts, normal operation SHALL resume with no extra latency.

Configuration
REQ-024 Macro EXTEND_HOLD_EN defined: when valid_in=0, immext SHALL hold its previous value (valid_out still goes 0).
REQ-025 Macro EXTEND_HOLD_EN undefined: immext SHALL load the computed value every cycle regardless of valid_in; valid_out behaviour is unchanged.

Verification
REQ-026 I-type: immsrc=00, LuiOP=0, instr=0x7FF00000, valid_in=1 -> next cycle immext=0x000007FF, valid_out=1; instr=0x80000000 -> 0xFFFFF800.
REQ-027 S-type: immsrc=01, instr=0x7E000F80 -> immext=0x000007FF.
REQ-028 B-type: immsrc=10, instr=0x7E000F00 -> immext=0x000007FE; instr=0x80000000 -> 0xFFFFF000.
REQ-029 J-type: immsrc=11, instr=0x7FFFF000 -> immext=0x000FFFFE; then LuiOP=1, instr=0xFFFFFFFF, any immsrc -> immext=0xFFFFF000.
REQ-030 Reset: drive a valid result, then rst=1 with valid_in=1 -> immext=0x00000000, valid_out=0 at next edge; after release, immext matches the new input one cycle later.
REQ-031 Hold: valid_in=0 for 3 cycles after a valid result -> valid_out=0; immext unchanged with EXTEND_HOLD_EN, tracks the current input without it.

Source files
------------

// File: rtl/extend_unit.sv
// RV32I immediate extender: decodes I/S/B/J/U immediates into a registered 32-bit value.
// Optional macro EXTEND_HOLD_EN: immext holds its previous value on cycles with valid_in=0.
module extend_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [1:0]  immsrc,
    input  logic [31:0] instr,
    input  logic        LuiOP,
    output logic [31:0] immext,
    output logic        valid_out
);

    localparam int DATA_W = 32;

    logic signed [DATA_W-1:0] imm_dec;
    logic signed [DATA_W-1:0] imm_d;
    logic signed [DATA_W-1:0] imm_q;
    logic                     vld_q;

    // Immediate field decode; instr[31] alone drives the sign fill in every format.
    function automatic logic signed [DATA_W-1:0] imm_decode(
        input logic [31:0] ins,
        input logic [1:0]  src,
        input logic        lui
    );
        logic signed [DATA_W-1:0] r;
        if (lui) begin
            r = {ins[31:12], 12'b0};
        end else begin
            case (src)
                2'b00:   r = {{20{ins[31]}}, ins[31:20]};
                2'b01:   r = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                2'b10:   r = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                2'b11:   r = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                default: r = {{20{ins[31]}}, ins[31:20]};
            endcase
        end
        return r;
    endfunction

    always_comb begin
        imm_dec = imm_decode(instr, immsrc, LuiOP);
`ifdef EXTEND_HOLD_EN
        imm_d   = valid_in ? imm_dec : imm_q;
`else
        imm_d   = imm_dec;
`endif
    end

    // Output register stage: one cycle from valid_in to valid_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            imm_q <= '0;
            vld_q <= 1'b0;
        end else begin
            imm_q <= imm_d;
            vld_q <= valid_in;
        end
    end

    assign immext    = imm_q;
    assign valid_out = vld_q;

endmodule

// File: tb/tb_extend_unit.sv
// Self-checking bench for extend_unit: directed literal checks plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_extend_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [1:0]  immsrc;
    logic [31:0] instr;
    logic        LuiOP;
    logic [31:0] immext;
    logic        valid_out;

`ifdef EXTEND_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    logic [31:0] m_imm;
    logic        m_vld;

    extend_unit dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .immsrc    (immsrc),
        .instr     (instr),
        .LuiOP     (LuiOP),
        .immext    (immext),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    // Reference: builds the immediate from field values with shifts and weights.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [1:0] src, input logic lui);
        int s;
        int sgn;
        s   = int'(ins);
        sgn = s >>> 31;
        if (lui) return ins & 32'hFFFF_F000;
        case (src)
            2'd0: return 32'(s >>> 20);
            2'd1: return 32'(((s >>> 25) <<< 5) | int'((ins >> 7) & 32'h1F));
            2'd2: return 32'((sgn <<< 12) + int'(((ins >> 7) & 1) << 11)
                           + int'(((ins >> 25) & 32'h3F) << 5) + int'(((ins >> 8) & 32'hF) << 1));
            default: return 32'((sgn <<< 20) + int'(((ins >> 12) & 32'hFF) << 12)
                           + int'(((ins >> 20) & 1) << 11) + int'(((ins >> 21) & 32'h3FF) << 1));
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_imm = 32'h0;
            m_vld = 1'b0;
        end else begin
            m_vld = valid_in;
            if (valid_in || !HOLD) m_imm = ref_imm(instr, immsrc, LuiOP);
        end
        if (rst) cmp_en = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_immext", immext, m_imm);
            chk("model_valid", {31'b0, valid_out}, {31'b0, m_vld});
        end
    end

    task automatic step(input logic r, input logic v, input logic [1:0] src,
                        input logic [31:0] ins, input logic lui);
        @(negedge clk);
        rst      = r;
        valid_in = v;
        immsrc   = src;
        instr    = ins;
        LuiOP    = lui;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; immsrc = 2'd0; instr = 32'h0; LuiOP = 1'b0;
        step(1, 1, 2'd0, 32'h7FF0_0000, 0);
        step(1, 0, 2'd0, 32'h0, 0);
        chk("reset_immext", immext, 32'h0);
        chk("reset_valid", {31'b0, valid_out}, 32'h0);

        step(0, 1, 2'd0, 32'h7FF0_0000, 0);
        chk("I_pos", immext, 32'h0000_07FF);
        chk("I_pos_valid", {31'b0, valid_out}, 32'h1);
        step(0, 1, 2'd0, 32'h8000_0000, 0);
        chk("I_neg", immext, 32'hFFFF_F800);
        step(0, 1, 2'd1, 32'h7E00_0F80, 0);
        chk("S_pos", immext, 32'h0000_07FF);
        step(0, 1, 2'd2, 32'h7E00_0F00, 0);
        chk("B_pos", immext, 32'h0000_07FE);
        step(0, 1, 2'd2, 32'h8000_0000, 0);
        chk("B_neg", immext, 32'hFFFF_F000);
        step(0, 1, 2'd3, 32'h7FFF_F000, 0);
        chk("J_pos", immext, 32'h000F_FFFE);
        step(0, 1, 2'($urandom_range(0, 3)), 32'hFFFF_FFFF, 1);
        chk("U_lui", immext, 32'hFFFF_F000);
        chk("model_pin", ref_imm(32'h8000_0000, 2'd3, 1'b0), 32'hFFF0_0000);

        step(0, 1, 2'd0, 32'h7FF0_0000, 0);
        step(1, 1, 2'd1, 32'h7E00_0F80, 0);
        chk("rst_prio_immext", immext, 32'h0);
        chk("rst_prio_valid", {31'b0, valid_out}, 32'h0);
        step(0, 1, 2'd0, 32'h1230_0000, 0);
        chk("after_rst", immext, 32'h0000_0123);
        chk("after_rst_valid", {31'b0, valid_out}, 32'h1);

        step(0, 1, 2'd0, 32'h7FF0_0000, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 2'd0, 32'h8000_0000, 0);
            chk("hold_valid", {31'b0, valid_out}, 32'h0);
            chk("hold_immext", immext, HOLD ? 32'h0000_07FF : 32'hFFFF_F800);
        end

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
                 2'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 4) == 0));
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
